// File: rtl/prim_clock_meas_multi.sv
// rtl/prim_clock_meas_multi.sv - multi-channel windowed event-count frequency checker
// Optional PRIM_CLK_MEAS_SNAPSHOT_EN adds snap_cnt_o holding the last window's final counts.
module prim_clock_meas_multi #(
  parameter int NumCh     = 4,
  parameter int CntW      = 10,
  parameter int WinW      = 12,
  parameter int ErrThresh = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [WinW-1:0]       win_cnt_i,
  input  logic [NumCh-1:0]      ev_i,
  input  logic [NumCh*CntW-1:0] max_cnt_i,
  input  logic [NumCh*CntW-1:0] min_cnt_i,
  input  logic                  err_clr_i,
`ifdef PRIM_CLK_MEAS_SNAPSHOT_EN
  output logic [NumCh*CntW-1:0] snap_cnt_o,
`endif
  output logic                  valid_o,
  output logic [NumCh-1:0]      fast_o,
  output logic [NumCh-1:0]      slow_o,
  output logic [NumCh-1:0]      err_o
);

  localparam int FcW = $clog2(ErrThresh + 1);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StEval} state_e;

  state_e                       state_q, state_d;
  logic [WinW-1:0]              win_q, eff_win_q, eff_in;
  logic [NumCh*CntW-1:0]        max_q, min_q;
  logic [NumCh-1:0][CntW-1:0]   cnt_q, cnt_nxt;
  logic [NumCh-1:0]             sat_q, sat_nxt, fast_nxt, slow_nxt;
  logic [NumCh-1:0][FcW-1:0]    fail_cnt_q;
  logic                         last_meas, sample_cfg, win_done;

  assign eff_in     = (win_cnt_i < WinW'(2)) ? WinW'(2) : win_cnt_i;
  assign last_meas  = (state_q == StMeas) && (win_q == eff_win_q - WinW'(1));
  assign win_done   = last_meas && en_i;
  assign sample_cfg = (state_d == StArm) || (state_d == StEval);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en_i) state_d = StArm;
      StArm:   state_d = StMeas;
      StMeas:  if (last_meas) state_d = StEval;
      StEval:  state_d = StMeas;
      default: state_d = StIdle;
    endcase
    if (!en_i) state_d = StIdle;
  end

  // Next counts include this cycle's strobe so the final Meas cycle is judged in its own window.
  always_comb begin
    cnt_nxt  = cnt_q;
    sat_nxt  = sat_q;
    fast_nxt = '0;
    slow_nxt = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (state_q == StMeas && ev_i[k]) begin
        if (&cnt_q[k]) sat_nxt[k] = 1'b1;
        else           cnt_nxt[k] = cnt_q[k] + CntW'(1);
      end
      fast_nxt[k] = sat_nxt[k] | (cnt_nxt[k] > max_q[k*CntW +: CntW]);
      slow_nxt[k] = cnt_nxt[k] < min_q[k*CntW +: CntW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      win_q     <= '0;
      eff_win_q <= WinW'(2);
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= '0;
      valid_o   <= 1'b0;
      fast_o    <= '0;
      slow_o    <= '0;
    end else begin
      state_q <= state_d;
      if (sample_cfg) begin
        eff_win_q <= eff_in;
        max_q     <= max_cnt_i;
        min_q     <= min_cnt_i;
      end
      if (state_q == StMeas) begin
        win_q <= win_q + WinW'(1);
        cnt_q <= cnt_nxt;
        sat_q <= sat_nxt;
      end else begin
        win_q <= '0;
        cnt_q <= '0;
        sat_q <= '0;
      end
      valid_o <= win_done;
      fast_o  <= win_done ? fast_nxt : '0;
      slow_o  <= win_done ? slow_nxt : '0;
    end
  end

  // A coincident clear never cancels a failure streak; only a pass or a standalone clear resets it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fail_cnt_q <= '0;
      err_o      <= '0;
    end else begin
      for (int k = 0; k < NumCh; k++) begin
        if (valid_o && (fast_o[k] || slow_o[k])) begin
          if (fail_cnt_q[k] != FcW'(ErrThresh)) fail_cnt_q[k] <= fail_cnt_q[k] + FcW'(1);
          if (fail_cnt_q[k] >= FcW'(ErrThresh - 1)) err_o[k] <= 1'b1;
          else if (err_clr_i)                      err_o[k] <= 1'b0;
        end else if (valid_o) begin
          fail_cnt_q[k] <= '0;
          if (err_clr_i) err_o[k] <= 1'b0;
        end else if (err_clr_i) begin
          fail_cnt_q[k] <= '0;
          err_o[k]      <= 1'b0;
        end
      end
    end
  end

`ifdef PRIM_CLK_MEAS_SNAPSHOT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       snap_cnt_o <= '0;
    else if (win_done) snap_cnt_o <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_prim_clock_meas_multi.sv
// tb/tb_prim_clock_meas_multi.sv - bench for prim_clock_meas_multi
module tb_prim_clock_meas_multi;
  localparam int NumCh = 4, CntW = 10, WinW = 12, ErrThresh = 2;
  localparam int MaxCnt = (1 << CntW) - 1;

  logic clk = 1'b0, rst_ni, en_i, err_clr_i, valid_o;
  logic [WinW-1:0] win_cnt_i;
  logic [NumCh-1:0] ev_i, fast_o, slow_o, err_o;
  logic [NumCh*CntW-1:0] max_cnt_i, min_cnt_i;
`ifdef PRIM_CLK_MEAS_SNAPSHOT_EN
  logic [NumCh*CntW-1:0] snap_cnt;
`endif

  always #5 clk = ~clk;

  prim_clock_meas_multi #(.NumCh(NumCh), .CntW(CntW), .WinW(WinW), .ErrThresh(ErrThresh)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .win_cnt_i(win_cnt_i), .ev_i(ev_i),
    .max_cnt_i(max_cnt_i), .min_cnt_i(min_cnt_i), .err_clr_i(err_clr_i),
`ifdef PRIM_CLK_MEAS_SNAPSHOT_EN
    .snap_cnt_o(snap_cnt),
`endif
    .valid_o(valid_o), .fast_o(fast_o), .slow_o(slow_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [WinW-1:0]            win;
    logic [NumCh-1:0][7:0]      per;
    logic [NumCh-1:0][CntW-1:0] mx;
    logic [NumCh-1:0][CntW-1:0] mn;
    logic [NumCh-1:0]           fast;
    logic [NumCh-1:0]           slow;
  } vec_t;

  int n_vec = 0, n_err = 0;
  int m_win, m_max[NumCh], m_min[NumCh], fc[NumCh];
  logic [NumCh-1:0] m_err;
  logic [NumCh-1:0][7:0] per;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic capture_cfg();
    m_win = (int'(win_cnt_i) < 2) ? 2 : int'(win_cnt_i);
    for (int k = 0; k < NumCh; k++) begin
      m_max[k] = int'(max_cnt_i[k*CntW +: CntW]);
      m_min[k] = int'(min_cnt_i[k*CntW +: CntW]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NumCh; k++) fc[k] = 0;
    m_err = '0;
  endtask

  task automatic randomize_cfg();
    win_cnt_i = WinW'($urandom_range(0, 30));
    for (int k = 0; k < NumCh; k++) begin
      max_cnt_i[k*CntW +: CntW] = CntW'($urandom_range(0, 20));
      min_cnt_i[k*CntW +: CntW] = CntW'($urandom_range(0, 20));
    end
  endtask

  task automatic arm();
    en_i = 1'b1; ev_i = '1;
    step();
    capture_cfg();
    chk("valid_arm", valid_o, 0);
    ev_i = '0;
    step();
  endtask

  // Result cycle, then the sticky-error bookkeeping: ErrThresh consecutive failures set err.
  task automatic eval_phase(input logic [NumCh-1:0] ef, input logic [NumCh-1:0] es, input bit clr,
                            input bit en_after, output logic [NumCh-1:0] df, output logic [NumCh-1:0] ds);
    chk("valid_eval", valid_o, 1);
    chk("fast", fast_o, ef);
    chk("slow", slow_o, es);
    df = fast_o; ds = slow_o;
    ev_i = 4'($urandom); err_clr_i = clr; en_i = en_after;
    step();
    err_clr_i = 1'b0;
    for (int k = 0; k < NumCh; k++) begin
      if (ef[k] || es[k]) begin
        if (fc[k] < ErrThresh) fc[k]++;
        if (fc[k] == ErrThresh) m_err[k] = 1'b1;
        else if (clr)           m_err[k] = 1'b0;
      end else begin
        fc[k] = 0;
        if (clr) m_err[k] = 1'b0;
      end
    end
    chk("err", err_o, m_err);
    chk("valid_pulse", valid_o, 0);
  endtask

  task automatic run_window(input bit rnd, input bit clr_mid, input bit clr_eval, input bit en_after,
                            output logic [NumCh-1:0] df, output logic [NumCh-1:0] ds);
    int sum[NumCh];
    logic [NumCh-1:0] ev, ef, es;
    for (int k = 0; k < NumCh; k++) sum[k] = 0;
    for (int i = 0; i < m_win; i++) begin
      chk("valid_meas", valid_o, 0);
      if (rnd) begin
        ev = 4'($urandom);
        if ($urandom_range(0, 7) == 0) randomize_cfg();
      end else begin
        for (int k = 0; k < NumCh; k++) ev[k] = (per[k] != 0) && (i % int'(per[k]) == 0);
      end
      ev_i = ev;
      err_clr_i = clr_mid && (i == 0);
      for (int k = 0; k < NumCh; k++) sum[k] += int'(ev[k]);
      step();
      err_clr_i = 1'b0;
      if (clr_mid && i == 0) begin
        model_reset();
        chk("err_clr", err_o, 0);
      end
    end
    for (int k = 0; k < NumCh; k++) begin
      ef[k] = (sum[k] > MaxCnt) || (sum[k] > m_max[k]);
      es[k] = sum[k] < m_min[k];
    end
    capture_cfg();
    eval_phase(ef, es, clr_eval, en_after, df, ds);
  endtask

  vec_t vecs[5];
  logic [NumCh-1:0] df, ds;
  int n;

  initial begin
    vecs[0] = '{win: 12'd100,  per: {8'd2, 8'd0, 8'd1, 8'd4},
                mx: {10'd60, 10'd10, 10'd50, 10'd30}, mn: {10'd40, 10'd1, 10'd0, 10'd20},
                fast: 4'b0010, slow: 4'b0100};
    vecs[1] = '{win: 12'd0,    per: {8'd2, 8'd0, 8'd1, 8'd1},
                mx: {10'd0, 10'd0, 10'd2, 10'd1}, mn: {10'd1, 10'd0, 10'd3, 10'd0},
                fast: 4'b1001, slow: 4'b0010};
    vecs[2] = '{win: 12'd1,    per: '0, mx: '0, mn: '0, fast: 4'b0000, slow: 4'b0000};
    vecs[3] = '{win: 12'd1100, per: {8'd1, 8'd0, 8'd0, 8'd0},
                mx: {10'd1023, 10'd0, 10'd0, 10'd0}, mn: '0, fast: 4'b1000, slow: 4'b0000};
    vecs[4] = '{win: 12'd10,   per: {8'd0, 8'd5, 8'd2, 8'd1},
                mx: {10'd0, 10'd1, 10'd5, 10'd5}, mn: {10'd0, 10'd3, 10'd5, 10'd20},
                fast: 4'b0101, slow: 4'b0101};

    rst_ni = 1'b0; en_i = 1'b0; err_clr_i = 1'b0; ev_i = '0;
    win_cnt_i = '0; max_cnt_i = '0; min_cnt_i = '0; per = '0;
    model_reset();
    m_win = 2;
    step(); step();
    chk("rst_valid", valid_o, 0); chk("rst_fast", fast_o, 0);
    chk("rst_slow", slow_o, 0);   chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      win_cnt_i = vecs[v].win; max_cnt_i = vecs[v].mx; min_cnt_i = vecs[v].mn; per = vecs[v].per;
      arm();
      run_window(1'b0, 1'b0, 1'b0, 1'b0, df, ds);
      chk("tbl_fast", df, vecs[v].fast);
      chk("tbl_slow", ds, vecs[v].slow);
    end

    // Reset mid-window while errors are set.
    win_cnt_i = 12'd100;
    arm();
    for (int i = 0; i < 5; i++) begin ev_i = '1; step(); end
    rst_ni = 1'b0;
    step();
    chk("rst_mid_valid", valid_o, 0); chk("rst_mid_fast", fast_o, 0);
    chk("rst_mid_slow", slow_o, 0);   chk("rst_mid_err", err_o, 0);
    model_reset();
    rst_ni = 1'b1; en_i = 1'b0; ev_i = '0;
    step();

    // Sticky error, clears, coincident clear, and an interleaved passing window.
    win_cnt_i = 12'd20; per = {8'd2, 8'd0, 8'd1, 8'd4};
    max_cnt_i = {10'd60, 10'd30, 10'd10, 10'd30}; min_cnt_i = {10'd0, 10'd1, 10'd0, 10'd0};
    arm();
    run_window(1'b0, 1'b0, 1'b0, 1'b1, df, ds); chk("err_w1", err_o, 4'b0000);
    run_window(1'b0, 1'b0, 1'b0, 1'b1, df, ds); chk("err_w2", err_o, 4'b0110);
    run_window(1'b0, 1'b1, 1'b0, 1'b1, df, ds); chk("err_w3", err_o, 4'b0000);
    run_window(1'b0, 1'b0, 1'b0, 1'b1, df, ds); chk("err_w4", err_o, 4'b0110);
    run_window(1'b0, 1'b0, 1'b1, 1'b1, df, ds); chk("err_setwins", err_o, 4'b0110);
    per[2] = 8'd1;
    run_window(1'b0, 1'b1, 1'b0, 1'b1, df, ds); chk("err_w6", err_o, 4'b0000);
    per[2] = 8'd0;
    run_window(1'b0, 1'b0, 1'b0, 1'b1, df, ds); chk("err_w7", err_o, 4'b0010);
    per[2] = 8'd1;
    run_window(1'b0, 1'b0, 1'b0, 1'b1, df, ds); chk("err_w8", err_o, 4'b0010);
    per[2] = 8'd0;
    run_window(1'b0, 1'b0, 1'b0, 1'b0, df, ds); chk("err_w9", err_o, 4'b0010);

    // Abort at Meas cycle 50, then re-enable and measure latency to the next result.
    win_cnt_i = 12'd100; max_cnt_i = '0; min_cnt_i = '0;
    arm();
    for (int i = 0; i < 50; i++) begin ev_i = '1; step(); end
    en_i = 1'b0; ev_i = '0;
    for (int i = 0; i < 4; i++) begin step(); chk("abort_valid", valid_o, 0); end
    en_i = 1'b1;
    n = 0;
    do begin step(); n++; end while (!valid_o && n < 200);
    chk("reenable_lat", n, 102);
    if (valid_o) begin
      capture_cfg();
      eval_phase(4'b0000, 4'b0000, 1'b0, 1'b0, df, ds);
    end

    // Random back-to-back windows with mid-window reconfiguration.
    randomize_cfg();
    arm();
    for (int w = 0; w < 40; w++)
      run_window(1'b1, 1'b0, $urandom_range(0, 3) == 0, w != 39, df, ds);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
